inst_fetch: RTL and testbench

Instruction-fetch front end: holds the program counter, drives the chip-enable and word address of the instruction ROM, and captures each returned word into a 2-entry prefetch buffer. It presents {pc, inst} pairs to the ID stage through a valid/ready handshake and redirects on branch/jump requests from the execute path. It replaces the bare PC register as the initiator side of the ROM interface; the ROM answers combinationally in the same cycle.

---
 rtl/inst_fetch_pkg.sv | 27 ++
 rtl/inst_fifo.sv | 59 +++++
 rtl/inst_fetch.sv | 86 ++++++++
 tb/tb_inst_fetch.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction-fetch front end.
// Latency: n/a (types, constants and a helper only).
// Backpressure: n/a.
package inst_fetch_pkg;

  localparam int unsigned InstAddrBus    = 32;
  localparam int unsigned InstBus        = 32;
  localparam int unsigned InstMemNumLog2 = 17;

  localparam logic [InstBus-1:0]     NopInst     = 32'h0000_0013;
  localparam logic                   ChipEnable  = 1'b1;
  localparam logic                   ChipDisable = 1'b0;
  localparam logic                   RstEnable   = 1'b1;
  localparam logic [InstAddrBus-1:0] ResetPc     = 32'h0000_0000;

  // One prefetch-buffer entry: the fetch address and the word the ROM returned.
  typedef struct packed {
    logic [InstAddrBus-1:0] pc;
    logic [InstBus-1:0]     inst;
  } fetch_entry_t;

  // Sequential fetch address; wraps modulo 2^32.
  function automatic logic [InstAddrBus-1:0] next_pc(input logic [InstAddrBus-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/inst_fifo.sv
// Synchronous prefetch FIFO of {pc, inst} entries with flush and combinational head.
// Latency: 1 cycle push-to-head; head readable combinationally.
// Backpressure: caller must only push when count_o < DEPTH or popping in the same cycle.
// Ports: clk_i/rst_i clock and sync reset; flush_i clears all entries;
//        push_i/push_dat_i write; pop_i drops head; head_o/count_o status.
module inst_fifo
  import inst_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PW   = $clog2(DEPTH),
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          push_i,
  input  fetch_entry_t  push_dat_i,
  input  logic          pop_i,
  output fetch_entry_t  head_o,
  output logic [CW-1:0] count_o
);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;

  logic clear;
  assign clear = (rst_i == RstEnable) || flush_i;

  // Storage needs no reset: count_q alone decides what is visible.
  always_ff @(posedge clk_i) begin
    if (push_i && !clear) begin
      mem_q[wr_ptr_q] <= push_dat_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // When full with simultaneous push/pop the write lands in the slot being
  // read; the read is combinational before the edge, so the head is intact.
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch front end: PC, ROM ce/addr, 2-entry prefetch buffer, redirect.
// Latency: fetch-to-present 1 cycle; redirect-to-present 2 cycles.
// Backpressure: id_ready_i low with a full buffer stops fetching (ce=0), head held.
// Ports: clk/rst sync active-high reset; branch_flag_i/branch_target_address_i redirect;
//        ce/addr/inst_i ROM (combinational answer); if_valid_o/if_pc_o/if_inst_o/id_ready_i to ID.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [InstAddrBus-1:0] RESET_PC   = ResetPc,
  parameter int unsigned            FIFO_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   branch_flag_i,
  input  logic [InstAddrBus-1:0] branch_target_address_i,
  output logic                   ce,
  output logic [InstAddrBus-1:0] addr,
  input  logic [InstBus-1:0]     inst_i,
  output logic                   if_valid_o,
  output logic [InstAddrBus-1:0] if_pc_o,
  output logic [InstBus-1:0]     if_inst_o,
  input  logic                   id_ready_i
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] FullCount = CW'(FIFO_DEPTH);

  logic [InstAddrBus-1:0] fetch_pc_q;
  logic [InstAddrBus-1:0] fetch_pc_d;
  logic                   rst_act;
  logic                   pop;
  logic                   space;
  logic                   fetch;
  logic [CW-1:0]          count;
  fetch_entry_t           head;
  fetch_entry_t           push_dat;

  assign rst_act = (rst == RstEnable);

  // A redirect hides the head combinationally so ID cannot consume a stale entry.
  assign if_valid_o = (count != '0) && !branch_flag_i && !rst_act;
  assign pop        = if_valid_o && id_ready_i;
  assign space      = (count < FullCount) || pop;
  assign fetch      = !rst_act && !branch_flag_i && space;

  assign ce   = fetch ? ChipEnable : ChipDisable;
  assign addr = fetch_pc_q;

  assign push_dat.pc   = fetch_pc_q;
  assign push_dat.inst = inst_i;

  assign if_pc_o   = if_valid_o ? head.pc   : '0;
  assign if_inst_o = if_valid_o ? head.inst : NopInst;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (branch_flag_i) begin
      fetch_pc_d = {branch_target_address_i[InstAddrBus-1:2], 2'b00};
    end else if (fetch) begin
      fetch_pc_d = next_pc(fetch_pc_q);
    end
  end

  // Reset takes priority over a simultaneous redirect.
  always_ff @(posedge clk) begin
    if (rst_act) begin
      fetch_pc_q <= RESET_PC;
    end else begin
      fetch_pc_q <= fetch_pc_d;
    end
  end

  inst_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_inst_fifo (
    .clk_i      (clk),
    .rst_i      (rst),
    .flush_i    (branch_flag_i),
    .push_i     (fetch),
    .push_dat_i (push_dat),
    .pop_i      (pop),
    .head_o     (head),
    .count_o    (count)
  );

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: reset, streaming, backpressure, redirects,
// reset with branch, and PC wrap on a second instance with RESET_PC=FFFF_FFF8.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
module tb_inst_fetch;
  import inst_fetch_pkg::*;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic        id_ready;

  logic        ce, ce2;
  logic [31:0] addr, addr2, rom_dat, rom_dat2;
  logic        vld, vld2;
  logic [31:0] if_pc, if_pc2, if_inst, if_inst2;

  // ROM model: word at address a is 1000_0000 + (a >> 2).
  assign rom_dat  = 32'h1000_0000 + (addr  >> 2);
  assign rom_dat2 = 32'h1000_0000 + (addr2 >> 2);

  inst_fetch dut (
    .clk                     (clk),
    .rst                     (rst),
    .branch_flag_i           (branch_flag),
    .branch_target_address_i (branch_target),
    .ce                      (ce),
    .addr                    (addr),
    .inst_i                  (rom_dat),
    .if_valid_o              (vld),
    .if_pc_o                 (if_pc),
    .if_inst_o               (if_inst),
    .id_ready_i              (id_ready)
  );

  inst_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk                     (clk),
    .rst                     (rst),
    .branch_flag_i           (1'b0),
    .branch_target_address_i (32'h0),
    .ce                      (ce2),
    .addr                    (addr2),
    .inst_i                  (rom_dat2),
    .if_valid_o              (vld2),
    .if_pc_o                 (if_pc2),
    .if_inst_o               (if_inst2),
    .id_ready_i              (1'b1)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  logic [31:0] wrap_pc   [4] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
  logic [31:0] wrap_inst [4] = '{32'h4FFF_FFFE, 32'h4FFF_FFFF, 32'h1000_0000, 32'h1000_0001};

  initial begin
    rst = 1'b1; branch_flag = 1'b0; branch_target = 32'h0; id_ready = 1'b1;

    // Reset state
    tick(); tick(); settle();
    chk("rst_ce",    {31'b0, ce}, 32'h0);
    chk("rst_addr",  addr,        32'h0);
    chk("rst_vld",   {31'b0, vld}, 32'h0);
    chk("rst_inst",  if_inst,     32'h0000_0013);
    chk("rst_pc",    if_pc,       32'h0);
    chk("rst_addr2", addr2,       32'hFFFF_FFF8);

    // Release: first fetch cycle
    tick(); rst = 1'b0; settle();
    chk("c0_ce",   {31'b0, ce},  32'h1);
    chk("c0_addr", addr,         32'h0);
    chk("c0_vld",  {31'b0, vld}, 32'h0);

    // Streaming, one per cycle; wrap instance in lock-step
    for (int k = 0; k < 4; k++) begin
      tick(); settle();
      chk("strm_vld",  {31'b0, vld}, 32'h1);
      chk("strm_pc",   if_pc,        32'(4 * k));
      chk("strm_inst", if_inst,      32'h1000_0000 + 32'(k));
      chk("wrap_pc",   if_pc2,       wrap_pc[k]);
      chk("wrap_inst", if_inst2,     wrap_inst[k]);
    end

    // Reset mid-stream, then backpressure from the first valid
    tick(); rst = 1'b1; id_ready = 1'b0; settle();
    tick(); rst = 1'b0; settle();
    chk("bp_c0_ce",  {31'b0, ce},  32'h1);
    chk("bp_c0_vld", {31'b0, vld}, 32'h0);
    tick(); settle();
    chk("bp_c1_pc",   if_pc, 32'h0);
    chk("bp_c1_addr", addr,  32'h4);
    for (int i = 2; i <= 5; i++) begin
      tick(); settle();
      chk("full_ce",   {31'b0, ce},  32'h0);
      chk("full_vld",  {31'b0, vld}, 32'h1);
      chk("full_pc",   if_pc,        32'h0);
      chk("full_inst", if_inst,      32'h1000_0000);
      chk("full_addr", addr,         32'h8);
    end
    tick(); id_ready = 1'b1; settle();
    chk("rel_pc0", if_pc,       32'h0);
    chk("rel_ce",  {31'b0, ce}, 32'h1);
    chk("rel_addr", addr,       32'h8);
    tick(); settle();
    chk("rel_pc4", if_pc, 32'h4);
    tick(); settle();
    chk("rel_pc8",   if_pc,   32'h8);
    chk("rel_inst8", if_inst, 32'h1000_0002);

    // Redirect while buffer full
    tick(); id_ready = 1'b0; settle();
    chk("pre_br_pc", if_pc,       32'hC);
    chk("pre_br_ce", {31'b0, ce}, 32'h0);
    tick(); branch_flag = 1'b1; branch_target = 32'h0000_0042; settle();
    chk("br_vld",  {31'b0, vld}, 32'h0);
    chk("br_ce",   {31'b0, ce},  32'h0);
    chk("br_inst", if_inst,      32'h0000_0013);
    chk("br_pc",   if_pc,        32'h0);
    tick(); branch_flag = 1'b0; settle();
    chk("br1_vld",  {31'b0, vld}, 32'h0);
    chk("br1_ce",   {31'b0, ce},  32'h1);
    chk("br1_addr", addr,         32'h40);
    tick(); settle();
    chk("br2_vld",  {31'b0, vld}, 32'h1);
    chk("br2_pc",   if_pc,        32'h40);
    chk("br2_inst", if_inst,      32'h1000_0010);

    // Branch coinciding with ready and valid head
    tick(); branch_flag = 1'b1; branch_target = 32'h0000_0100; id_ready = 1'b1; settle();
    chk("brr_vld", {31'b0, vld}, 32'h0);
    chk("brr_ce",  {31'b0, ce},  32'h0);
    tick(); branch_flag = 1'b0; settle();
    chk("brr1_vld",  {31'b0, vld}, 32'h0);
    chk("brr1_addr", addr,         32'h100);
    tick(); settle();
    chk("brr2_pc",   if_pc,   32'h100);
    chk("brr2_inst", if_inst, 32'h1000_0040);
    tick(); settle();
    chk("brr3_pc", if_pc, 32'h104);

    // Fill, then reset together with branch
    tick(); id_ready = 1'b0; settle();
    chk("fill_pc", if_pc,       32'h108);
    chk("fill_ce", {31'b0, ce}, 32'h1);
    tick(); settle();
    chk("fill2_ce", {31'b0, ce}, 32'h0);
    tick(); rst = 1'b1; branch_flag = 1'b1; branch_target = 32'h0000_0200; settle();
    chk("rb_vld", {31'b0, vld}, 32'h0);
    tick(); branch_flag = 1'b0; settle();
    chk("rb1_vld",  {31'b0, vld}, 32'h0);
    chk("rb1_inst", if_inst,      32'h0000_0013);
    chk("rb1_pc",   if_pc,        32'h0);
    chk("rb1_addr", addr,         32'h0);
    chk("rb1_ce",   {31'b0, ce},  32'h0);
    tick(); rst = 1'b0; settle();
    chk("rb2_ce",   {31'b0, ce},  32'h1);
    chk("rb2_addr", addr,         32'h0);
    chk("rb2_vld",  {31'b0, vld}, 32'h0);
    tick(); settle();
    chk("rb3_vld", {31'b0, vld}, 32'h1);
    chk("rb3_pc",  if_pc,        32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
